// File: rtl/udp_frame_packer.sv
// udp_frame_packer
//   Frames calibration, status-message and acquisition data into a
//   valid/ready beat stream for the UDP TX engine. Every frame starts with a
//   header beat {marker, frame_cnt, fee_mode, payload count, 0...}.
//
//   Optional feature: define UDP_FRAME_CHECKSUM_EN to append one trailer beat
//   per frame. Each trailer lane is the lane-wise sum (mod 2^DATAWIDTH) of the
//   header and all payload beats. udp_tx_last then marks the trailer.
//
// Ports
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   fee_mode                0 idle, 1 calibration, 2 acquisition (sampled at frame start)
//   cal_req, msg_req        single-cycle frame requests (latched into pending flags)
//   adc_baseline/adc_noise  calibration payload, snapshotted at frame start
//   acq_data/valid/ready    acquisition input stream
//   tx_req                  downstream ready
//   udp_tx_data/valid/last  output beat stream
//   frame_cnt               completed frame count (wraps)
//   busy                    frame engine not idle
module udp_frame_packer #(
    parameter int          DATAWIDTH  = 16,
    parameter int          ADC_CHANEL = 8,
    parameter int          ACQ_BEATS  = 64,
    parameter int          CNT_WIDTH  = 11,
    parameter logic [15:0] CAL_MARKER = 16'h3456,
    parameter logic [15:0] MSG_MARKER = 16'h0666,
    parameter logic [15:0] ACQ_MARKER = 16'h0ACE
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [4:0]                       fee_mode,
    input  logic                             cal_req,
    input  logic                             msg_req,
    input  logic [ADC_CHANEL*DATAWIDTH-1:0]  adc_baseline,
    input  logic [ADC_CHANEL*DATAWIDTH-1:0]  adc_noise,
    input  logic [ADC_CHANEL*DATAWIDTH-1:0]  acq_data,
    input  logic                             acq_valid,
    output logic                             acq_ready,
    input  logic                             tx_req,
    output logic [ADC_CHANEL*DATAWIDTH-1:0]  udp_tx_data,
    output logic                             udp_tx_valid,
    output logic                             udp_tx_last,
    output logic [CNT_WIDTH-1:0]             frame_cnt,
    output logic                             busy
);
    localparam int W    = ADC_CHANEL * DATAWIDTH;
    localparam int BC_W = $clog2(ACQ_BEATS + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
`ifdef UDP_FRAME_CHECKSUM_EN
        S_TRL,
`endif
        S_PAY
    } state_t;

    typedef enum logic [1:0] {T_CAL, T_MSG, T_ACQ} ftype_t;

`ifdef UDP_FRAME_CHECKSUM_EN
    localparam logic   HAS_TRL = 1'b1;
    localparam state_t S_END   = S_TRL;   // where a frame goes after its last payload beat
`else
    localparam logic   HAS_TRL = 1'b0;
    localparam state_t S_END   = S_IDLE;
`endif

    state_t               state_q, state_d;
    ftype_t               type_q, type_d;
    logic [BC_W-1:0]      bcnt_q, bcnt_d;
    logic [W-1:0]         data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [W-1:0]         bl_q, bl_d, nz_q, nz_d;
    logic                 cal_flag_q, cal_flag_d, msg_flag_q, msg_flag_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_now;

    logic   load, last_xfer, cal_pend, msg_pend, acq_go, idle_like, acq_last;
    logic   start;
    ftype_t start_type;
    logic [W-1:0] hdr;

    // The output register may take a new beat when empty or when its beat leaves.
    assign load      = !valid_q || tx_req;
    assign last_xfer = valid_q && last_q && tx_req;
    // Header count must already include a frame finishing this very cycle.
    assign cnt_now   = cnt_q + CNT_WIDTH'(last_xfer);
    assign cal_pend  = cal_flag_q || cal_req;
    assign msg_pend  = msg_flag_q || msg_req;
    assign acq_go    = (fee_mode == 5'd2) && acq_valid;
    assign acq_last  = (bcnt_q == BC_W'(ACQ_BEATS - 1));

    // A trailer-less message frame is complete once its header is in the
    // output register, so HDR behaves like IDLE and the next frame can follow
    // without a gap.
`ifdef UDP_FRAME_CHECKSUM_EN
    assign idle_like = (state_q == S_IDLE);
`else
    assign idle_like = (state_q == S_IDLE) || (state_q == S_HDR && type_q == T_MSG);
`endif

    assign acq_ready = (state_q == S_PAY) && (type_q == T_ACQ) && load;

    always_comb begin
        start      = 1'b0;
        start_type = T_CAL;
        if (load && idle_like) begin
            if (cal_pend) begin
                start = 1'b1; start_type = T_CAL;
            end else if (msg_pend) begin
                start = 1'b1; start_type = T_MSG;
            end else if (acq_go) begin
                start = 1'b1; start_type = T_ACQ;
            end
        end
    end

    always_comb begin
        hdr = '0;
        case (start_type)
            T_CAL:   hdr[0 +: DATAWIDTH] = DATAWIDTH'(CAL_MARKER);
            T_MSG:   hdr[0 +: DATAWIDTH] = DATAWIDTH'(MSG_MARKER);
            default: hdr[0 +: DATAWIDTH] = DATAWIDTH'(ACQ_MARKER);
        endcase
        hdr[DATAWIDTH +: DATAWIDTH]   = DATAWIDTH'(cnt_now);
        hdr[2*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(fee_mode);
        case (start_type)
            T_CAL:   hdr[3*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(2);
            T_MSG:   hdr[3*DATAWIDTH +: DATAWIDTH] = '0;
            default: hdr[3*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(ACQ_BEATS);
        endcase
    end

`ifdef UDP_FRAME_CHECKSUM_EN
    logic [W-1:0] sum_q;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        bcnt_d     = bcnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        bl_d       = bl_q;
        nz_d       = nz_q;
        cal_flag_d = cal_pend && !(start && start_type == T_CAL);
        msg_flag_d = msg_pend && !(start && start_type == T_MSG);
        if (load) begin
            if (idle_like) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    data_d  = hdr;
                    valid_d = 1'b1;
                    last_d  = (start_type == T_MSG) && !HAS_TRL;
                    type_d  = start_type;
                    bcnt_d  = '0;
                    state_d = S_HDR;
                    if (start_type == T_CAL) begin
                        bl_d = adc_baseline;
                        nz_d = adc_noise;
                    end
                end
            end else begin
                case (state_q)
                    S_HDR: begin
                        state_d = S_PAY;
                        last_d  = 1'b0;
                        if (type_q == T_CAL) begin
                            data_d  = bl_q;
                            valid_d = 1'b1;
                            bcnt_d  = BC_W'(1);
                        end else if (type_q == T_ACQ) begin
                            valid_d = 1'b0;   // acq beats arrive through acq_ready in PAY
                        end else begin
`ifdef UDP_FRAME_CHECKSUM_EN
                            data_d  = sum_q;  // message trailer covers the header only
                            valid_d = 1'b1;
                            last_d  = 1'b1;
`else
                            valid_d = 1'b0;
`endif
                            state_d = S_IDLE;
                        end
                    end
                    S_PAY: begin
                        if (type_q == T_ACQ) begin
                            if (acq_valid) begin
                                data_d  = acq_data;
                                valid_d = 1'b1;
                                bcnt_d  = bcnt_q + BC_W'(1);
                                last_d  = acq_last && !HAS_TRL;
                                if (acq_last) state_d = S_END;
                            end else begin
                                valid_d = 1'b0;   // upstream gap: bubble
                            end
                        end else begin
                            data_d  = nz_q;
                            valid_d = 1'b1;
                            last_d  = !HAS_TRL;
                            state_d = S_END;
                        end
                    end
`ifdef UDP_FRAME_CHECKSUM_EN
                    S_TRL: begin
                        data_d  = sum_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            type_q     <= T_CAL;
            bcnt_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            bl_q       <= '0;
            nz_q       <= '0;
            cal_flag_q <= 1'b0;
            msg_flag_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            bcnt_q     <= bcnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            bl_q       <= bl_d;
            nz_q       <= nz_d;
            cal_flag_q <= cal_flag_d;
            msg_flag_q <= msg_flag_d;
            cnt_q      <= cnt_now;
        end
    end

`ifdef UDP_FRAME_CHECKSUM_EN
    // Running lane sums: restart on each header, accumulate every payload beat.
    logic ld_hdr, ld_pay;
    assign ld_hdr = start;
    assign ld_pay = load && valid_d &&
                    ((state_q == S_PAY) || (state_q == S_HDR && type_q == T_CAL));

    for (genvar l = 0; l < ADC_CHANEL; l++) begin : g_sum
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst)
                sum_q[l*DATAWIDTH +: DATAWIDTH] <= '0;
            else if (ld_hdr)
                sum_q[l*DATAWIDTH +: DATAWIDTH] <= hdr[l*DATAWIDTH +: DATAWIDTH];
            else if (ld_pay)
                sum_q[l*DATAWIDTH +: DATAWIDTH] <= sum_q[l*DATAWIDTH +: DATAWIDTH]
                                                 + data_d[l*DATAWIDTH +: DATAWIDTH];
        end
    end
`endif

    assign udp_tx_data  = data_q;
    assign udp_tx_valid = valid_q;
    assign udp_tx_last  = last_q;
    assign frame_cnt    = cnt_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_frame_packer.sv
module tb_udp_frame_packer;
    localparam int DW = 16;
    localparam int CH = 8;
    localparam int AB = 4;
    localparam int CW = 2;
    localparam int W  = DW * CH;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [4:0]    fee_mode = '0;
    logic          cal_req = 1'b0, msg_req = 1'b0;
    logic [W-1:0]  adc_baseline = '0, adc_noise = '0, acq_data = '0;
    logic          acq_valid = 1'b0, acq_ready;
    logic          tx_req = 1'b1;
    logic [W-1:0]  udp_tx_data;
    logic          udp_tx_valid, udp_tx_last;
    logic [CW-1:0] frame_cnt;
    logic          busy;

    udp_frame_packer #(.DATAWIDTH(DW), .ADC_CHANEL(CH), .ACQ_BEATS(AB), .CNT_WIDTH(CW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fee_mode(fee_mode),
        .cal_req(cal_req), .msg_req(msg_req),
        .adc_baseline(adc_baseline), .adc_noise(adc_noise),
        .acq_data(acq_data), .acq_valid(acq_valid), .acq_ready(acq_ready),
        .tx_req(tx_req), .udp_tx_data(udp_tx_data), .udp_tx_valid(udp_tx_valid),
        .udp_tx_last(udp_tx_last), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        bit           btb;   // must follow the previous last beat with no gap
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           checks = 0, failures = 0;
    int           cyc = 0, last_cyc = -10, mcnt = 0;
    logic [W-1:0] csum;
    logic [W-1:0] calp[4], acqp[4], nop[4];

`ifdef UDP_FRAME_CHECKSUM_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] hdr(input logic [15:0] mk, input int cnt, input int mode, input int n);
        logic [W-1:0] h;
        h = '0;
        h[15:0]  = mk;
        h[31:16] = 16'(cnt);
        h[47:32] = 16'(mode);
        h[63:48] = 16'(n);
        return h;
    endfunction

    task automatic exp_beat(input logic [W-1:0] d, input logic lst, input bit btb);
        exp_t x;
        x.data = d; x.last = lst; x.btb = btb;
        q.push_back(x);
        for (int l = 0; l < CH; l++) csum[l*DW +: DW] += d[l*DW +: DW];
    endtask

    task automatic exp_frame(input logic [15:0] mk, input int mode, input int n,
                             input logic [W-1:0] p[4], input bit btb);
        csum = '0;
        exp_beat(hdr(mk, mcnt, mode, n), !TRL && n == 0, btb);
        for (int i = 0; i < n; i++) exp_beat(p[i], !TRL && i == n - 1, 1'b0);
        if (TRL) exp_beat(csum, 1'b1, 1'b0);
        mcnt = (mcnt + 1) % (1 << CW);
    endtask

    // Monitor: every transferred beat must match the head of the queue.
    always @(negedge sys_clk) begin
        if (!sys_rst && udp_tx_valid && tx_req) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_beat actual=%h required=none", udp_tx_data);
            end else begin
                e = q.pop_front();
                chk("beat_data", udp_tx_data, e.data);
                chk("beat_last", W'(udp_tx_last), W'(e.last));
                if (e.btb) chk("back_to_back_cycle", W'(cyc), W'(last_cyc + 1));
            end
            if (udp_tx_last) last_cyc = cyc;
        end
    end

    task automatic pulse(input bit c, input bit m);
        @(posedge sys_clk); #1;
        cal_req = c; msg_req = m;
        @(posedge sys_clk); #1;
        cal_req = 1'b0; msg_req = 1'b0;
    endtask

    task automatic acq_send(input logic [W-1:0] d);
        int  t;
        logic hs;
        t = 0; hs = 1'b0;
        acq_data = d; acq_valid = 1'b1;
        while (!hs && t < 200) begin
            @(negedge sys_clk); hs = acq_ready;
            @(posedge sys_clk); #1; t++;
        end
        acq_valid = 1'b0;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL acq_handshake_timeout actual=%0d required=<200", t);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q.size() != 0 || udp_tx_valid || busy) && t < 300) begin
            @(negedge sys_clk); t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL %s_drain_timeout actual=%0d_queued required=0", name, q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] hm;
        for (int i = 0; i < CH; i++) begin
            adc_baseline[i*DW +: DW] = 16'h0100 + 16'(i);
            adc_noise[i*DW +: DW]    = 16'h0010 + 16'(i);
        end
        calp[0] = adc_baseline; calp[1] = adc_noise; calp[2] = '0; calp[3] = '0;
        for (int i = 0; i < 4; i++) begin acqp[i] = W'(i + 1); nop[i] = '0; end

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_valid", W'(udp_tx_valid), '0);
        chk("rst_last", W'(udp_tx_last), '0);
        chk("rst_data", udp_tx_data, '0);
        chk("rst_frame_cnt", W'(frame_cnt), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_acq_ready", W'(acq_ready), '0);
        @(negedge sys_clk); sys_rst = 1'b0;

        // Calibration frame
        fee_mode = 5'd1;
        exp_frame(16'h3456, 1, 2, calp, 1'b0);
        pulse(1'b1, 1'b0);
        drain("cal");
        chk("cal_frame_cnt", W'(frame_cnt), W'(1));

        // Message frame under back-pressure
        @(posedge sys_clk); #1; tx_req = 1'b0;
        hm = hdr(16'h0666, mcnt, 1, 0);
        exp_frame(16'h0666, 1, 0, nop, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (5) begin
            @(negedge sys_clk);
            chk("msg_hold_valid", W'(udp_tx_valid), W'(1));
            chk("msg_hold_data", udp_tx_data, hm);
            chk("msg_hold_last", W'(udp_tx_last), W'(!TRL));
            chk("msg_acq_ready", W'(acq_ready), '0);
        end
        @(posedge sys_clk); #1; tx_req = 1'b1;
        drain("msg");
        chk("msg_frame_cnt", W'(frame_cnt), W'(2));

        // Acquisition with an upstream gap after beat 2
        fee_mode = 5'd2;
        exp_frame(16'h0ACE, 2, AB, acqp, 1'b0);
        acq_send(acqp[0]); acq_send(acqp[1]);
        repeat (3) @(posedge sys_clk);
        #1;
        acq_send(acqp[2]); acq_send(acqp[3]);
        drain("acq");
        chk("acq_frame_cnt", W'(frame_cnt), W'(3));

        // Cal and msg requested together during an acq frame
        exp_frame(16'h0ACE, 2, AB, acqp, 1'b0);
        exp_frame(16'h3456, 2, 2, calp, 1'b1);
        exp_frame(16'h0666, 2, 0, nop, 1'b1);
        acq_send(acqp[0]);
        pulse(1'b1, 1'b1);
        acq_send(acqp[1]); acq_send(acqp[2]); acq_send(acqp[3]);
        drain("mixed");
        chk("mixed_frame_cnt", W'(frame_cnt), W'((3 + 3) % 4));

        // Reset mid-frame with a payload beat held on the output
        exp_frame(16'h0ACE, 2, AB, acqp, 1'b0);
        acq_send(acqp[0]); acq_send(acqp[1]);
        tx_req = 1'b0; acq_data = acqp[2]; acq_valid = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("pre_rst_valid", W'(udp_tx_valid), W'(1));
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_valid", W'(udp_tx_valid), '0);
        chk("async_rst_busy", W'(busy), '0);
        chk("async_rst_frame_cnt", W'(frame_cnt), '0);
        q.delete(); mcnt = 0;
        acq_valid = 1'b0; fee_mode = 5'd0; tx_req = 1'b1;
        @(negedge sys_clk); sys_rst = 1'b0;

        // Five message frames: header lane1 runs 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            exp_frame(16'h0666, 0, 0, nop, 1'b0);
            pulse(1'b0, 1'b1);
            drain("wrap");
        end
        chk("wrap_frame_cnt", W'(frame_cnt), W'(1));
        chk("queue_empty", W'(q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
